// File: rtl/ifetch_pkg.sv
// Shared widths, the fetch queue entry type and a PC alignment helper for the
// instruction fetch front end.
package ifetch_pkg;

    localparam int ADDR_W     = 32;
    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Synchronous queue of fetched {pc, inst} entries with flush. The head is read
// from registered storage, so a push is never visible at the output in the same cycle.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  fetch_entry_t            i_push_data,
    input  logic                    i_pop,
    output fetch_entry_t            o_head,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The credit scheme upstream must never let a push land on a full queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_do_push && !w_do_pop && (r_count == FULL_CNT)));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: owns the fetch PC, issues word reads under a credit limit and
// queues returned words with their PCs; a redirect flushes and drops in-flight data.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_inflight;
    logic              w_fire;
    logic              w_rsp_keep;
    logic              w_rsp_discard;
    logic              w_pop;
    logic [ADDR_W-1:0] w_redirect_pc;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;

    // Queue slots already used plus slots promised to outstanding reads.
    assign w_inflight     = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (w_inflight < DEPTH_C);
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    assign w_rsp_keep     = imem_rsp_valid && !redirect_valid && (r_drop == '0);
    assign w_rsp_discard  = imem_rsp_valid && !redirect_valid && (r_drop != '0);

    assign inst_valid     = (w_count != '0) && !redirect_valid;
    assign w_pop          = inst_valid && inst_ready;
    assign w_redirect_pc  = word_align(redirect_pc);
    assign w_push_data    = '{pc: r_rsp_pc, inst: imem_rsp_data};
    assign inst_data      = w_head.inst;
    assign inst_pc        = w_head.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight becomes garbage, minus the response landing now.
            r_fetch_pc    <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_drop        <= r_drop + r_outstanding - {{(CW-1){1'b0}}, imem_rsp_valid};
            r_outstanding <= '0;
        end else begin
            if (w_fire)        r_fetch_pc <= r_fetch_pc + ADDR_W'(INST_BYTES);
            if (w_rsp_keep)    r_rsp_pc   <= r_rsp_pc + ADDR_W'(INST_BYTES);
            if (w_rsp_discard) r_drop     <= r_drop - 1'b1;
            case ({w_fire, w_rsp_keep})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_rsp_keep),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

endmodule
